// File: rtl/riscv_pkg.sv
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared widths, the default reset PC and the fetch buffer entry
//             type used by the instruction fetch stage.
//  Contents : XLEN, ILEN, RESET_PC_DEFAULT, fetch_entry_t
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // One buffered fetch result. misaligned marks a synthetic entry created by
   // a redirect to a non-word-aligned target (instr is zero in that case).
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
      logic            misaligned;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
//  Module   : fetch_unit_if
//  Purpose  : Bundles the fetch stage's handshaked buses: instruction-memory
//             request/response, datapath redirect and the instruction
//             hand-off to the datapath.
//  Modports : master - the fetch unit
//             slave  - the environment (memory + datapath)
//  Options  : FETCH_MISALIGN_EN adds instr_misaligned.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if;
   import riscv_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [ILEN-1:0] imem_resp_data;

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   logic            instr_valid;
   logic            instr_ready;
   logic [ILEN-1:0] instr;
   logic [XLEN-1:0] instr_pc;
`ifdef FETCH_MISALIGN_EN
   logic            instr_misaligned;
`endif

   modport master (
      output imem_req_valid,
      input  imem_req_ready,
      output imem_req_addr,
      input  imem_resp_valid,
      input  imem_resp_data,
      input  redirect_valid,
      input  redirect_pc,
      output instr_valid,
      input  instr_ready,
      output instr,
`ifdef FETCH_MISALIGN_EN
      output instr_misaligned,
`endif
      output instr_pc
   );

   modport slave (
      input  imem_req_valid,
      output imem_req_ready,
      input  imem_req_addr,
      output imem_resp_valid,
      output imem_resp_data,
      output redirect_valid,
      output redirect_pc,
      input  instr_valid,
      output instr_ready,
      input  instr,
`ifdef FETCH_MISALIGN_EN
      input  instr_misaligned,
`endif
      input  instr_pc
   );

endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : Synchronous in-order buffer of fetch_entry_t. No bypass: an
//             entry pushed in cycle N is first visible at o_head in N+1.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             i_push, i_entry  - write one entry
//             i_pop            - drop the head entry (ignored when empty)
//             i_flush          - discard all entries (wins over push/pop)
//             o_head           - current head entry (registered state)
//             o_count          - number of valid entries
//             o_full, o_empty  - status
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  wire logic                       clk,
   input  wire logic                       rst,
   input  wire logic                       i_push,
   input  wire fetch_entry_t               i_entry,
   input  wire logic                       i_pop,
   input  wire logic                       i_flush,
   output fetch_entry_t                    o_head,
   output logic [$clog2(DEPTH+1)-1:0]      o_count,
   output logic                            o_full,
   output logic                            o_empty
);

   localparam int c_PW = $clog2(DEPTH);
   localparam int c_CW = $clog2(DEPTH+1);

   fetch_entry_t      r_mem [DEPTH];
   logic [c_PW-1:0]   r_wr_ptr;
   logic [c_PW-1:0]   r_rd_ptr;
   logic [c_CW-1:0]   r_count;

   logic              w_push_en;
   logic              w_pop_en;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == c_CW'(DEPTH));
   assign w_push_en = i_push && !i_flush;
   assign w_pop_en  = i_pop && !o_empty && !i_flush;

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_en) r_wr_ptr <= r_wr_ptr + c_PW'(1);
         if (w_pop_en)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
         r_count <= r_count + c_CW'(w_push_en) - c_CW'(w_pop_en);
      end
   end

   // Storage carries no reset; validity is tracked by r_count alone.
   always_ff @(posedge clk) begin
      if (w_push_en) r_mem[r_wr_ptr] <= i_entry;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // The producer's credit scheme must never push into a full buffer.
   always_ff @(posedge clk) begin
      if (!rst && !i_flush) begin
         assert (!(i_push && o_full && !i_pop));
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Pipelined instruction fetch. Issues sequential word fetches
//             against a handshaked instruction memory, buffers responses in
//             order and presents {pc, instr} to the datapath over
//             valid/ready. Redirects flush the buffer and discard all
//             responses to requests issued before the redirect.
//  Ports    : clk, rst - clock, synchronous active-high reset
//             bus      - fetch_unit_if.master (imem req/resp, redirect,
//                        instruction hand-off)
//  Params   : DEPTH    - buffer entries = max outstanding requests (2^n, >=2)
//             RESET_PC - first fetch address after reset
//  Options  : FETCH_MISALIGN_EN - a redirect to a non-word-aligned PC yields a
//             single entry flagged instr_misaligned and halts fetching until
//             the next redirect. Without it the low PC bits are cleared.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
   import riscv_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  wire logic   clk,
   input  wire logic   rst,
   fetch_unit_if.master bus
);

   localparam int c_CW = $clog2(DEPTH+1);

   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_resp_pc;
   logic [c_CW-1:0] r_outstanding;
   logic [c_CW-1:0] r_drop_cnt;
   logic            r_boot;

   logic [c_CW-1:0] w_count;
   logic            w_fifo_full;
   logic            w_fifo_empty;
   fetch_entry_t    w_head;
   fetch_entry_t    w_push_entry;

   logic [c_CW:0]   w_credit_sum;
   logic [c_CW-1:0] w_outstanding_nxt;
   logic [XLEN-1:0] w_redirect_pc_al;
   logic            w_req_valid;
   logic            w_req_fire;
   logic            w_resp;
   logic            w_keep;
   logic            w_push;
   logic            w_pop;
   logic            w_instr_valid;
   logic            w_fetch_en;
   logic            w_mis_push;
   logic            w_unused;

   // ------------------------------------------------------------------------
   // Request credit: in-flight requests plus buffered entries may never exceed
   // DEPTH, so every response has a guaranteed slot. Only registered state is
   // used, so a pop in this cycle does not free a credit until the next one.
   // ------------------------------------------------------------------------
   assign w_credit_sum = {1'b0, r_outstanding} + {1'b0, w_count};
   assign w_req_valid  = !rst && !r_boot && !bus.redirect_valid && w_fetch_en
                         && (w_credit_sum < (c_CW+1)'(DEPTH));
   assign w_req_fire   = w_req_valid && bus.imem_req_ready;

   assign w_resp            = bus.imem_resp_valid;
   assign w_outstanding_nxt = r_outstanding + c_CW'(w_req_fire) - c_CW'(w_resp);
   assign w_redirect_pc_al  = {bus.redirect_pc[XLEN-1:2], 2'b00};

   // A response is kept only if no older redirect still owes drops and no
   // redirect is happening now.
   assign w_keep = w_resp && (r_drop_cnt == '0) && !bus.redirect_valid;
   assign w_push = w_keep || w_mis_push;

   assign w_instr_valid = !rst && !w_fifo_empty;
   assign w_pop         = w_instr_valid && bus.instr_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_outstanding <= w_outstanding_nxt;
         if (bus.redirect_valid) begin
            r_fetch_pc <= w_redirect_pc_al;
            r_resp_pc  <= w_redirect_pc_al;
            // Every request still in flight after this edge belongs to the
            // abandoned stream. Drops already owed are a subset of those, so
            // the new drop count is exactly the post-edge outstanding count.
            r_drop_cnt <= w_outstanding_nxt;
         end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_keep)     r_resp_pc  <= r_resp_pc + 32'd4;
            if (w_resp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - c_CW'(1);
         end
      end
   end

   // Holds off requests for the cycle following reset.
   always_ff @(posedge clk) begin
      r_boot <= rst;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert ((r_drop_cnt <= r_outstanding) && (r_outstanding <= c_CW'(DEPTH)));
      end
   end

`ifdef FETCH_MISALIGN_EN
   // ------------------------------------------------------------------------
   // Misaligned-redirect handling: FETCH -> MIS_PUSH (emit flagged entry) ->
   // HALT (no requests) until a redirect restarts fetching.
   // ------------------------------------------------------------------------
   localparam logic [1:0] c_ST_FETCH    = 2'd0;
   localparam logic [1:0] c_ST_MIS_PUSH = 2'd1;
   localparam logic [1:0] c_ST_HALT     = 2'd2;

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic [XLEN-1:0] r_mis_pc;

   always_ff @(posedge clk) begin
      if (rst) r_state <= c_ST_FETCH;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (bus.redirect_valid) r_mis_pc <= bus.redirect_pc;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.redirect_valid) begin
         w_state_nxt = (bus.redirect_pc[1:0] != 2'b00) ? c_ST_MIS_PUSH : c_ST_FETCH;
      end else begin
         case (r_state)
            c_ST_MIS_PUSH: w_state_nxt = c_ST_HALT;
            default:       w_state_nxt = r_state;
         endcase
      end
   end

   always_comb begin
      w_fetch_en = (r_state == c_ST_FETCH);
      w_mis_push = (r_state == c_ST_MIS_PUSH) && !bus.redirect_valid;
   end

   always_comb begin
      w_push_entry.pc         = r_resp_pc;
      w_push_entry.instr      = bus.imem_resp_data;
      w_push_entry.misaligned = 1'b0;
      if (w_mis_push) begin
         w_push_entry.pc         = r_mis_pc;
         w_push_entry.instr      = '0;
         w_push_entry.misaligned = 1'b1;
      end
   end

   assign bus.instr_misaligned = w_head.misaligned;
   assign w_unused             = w_fifo_full;
`else
   assign w_fetch_en = 1'b1;
   assign w_mis_push = 1'b0;

   always_comb begin
      w_push_entry.pc         = r_resp_pc;
      w_push_entry.instr      = bus.imem_resp_data;
      w_push_entry.misaligned = 1'b0;
   end

   assign w_unused = w_fifo_full ^ w_head.misaligned ^ (^bus.redirect_pc[1:0]);
`endif

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_entry (w_push_entry),
      .i_pop   (w_pop),
      .i_flush (bus.redirect_valid),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = r_fetch_pc;
   assign bus.instr_valid    = w_instr_valid;
   assign bus.instr          = w_head.instr;
   assign bus.instr_pc       = w_head.pc;

endmodule

`default_nettype wire
